// File: rtl/hilo_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_pkg
//   Shared encodings for the HI/LO multiply/divide unit:
//   - md_op_e  : MdOp operation codes (3-bit field, all 8 codes defined)
//   - state_e  : control FSM states
//   - DIVZERO_LO : LO value written on a divide by zero
//   - helpers classifying an operation as signed / divide
// -----------------------------------------------------------------------------
package hilo_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_MADD  = 3'd2,
    MD_MSUB  = 3'd3,
    MD_DIV   = 3'd4,
    MD_DIVU  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  // Operations whose operands are treated as two's complement.
  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
//   Iteration registers for the HI/LO unit. One shared 2*WIDTH register holds
//   either the shift-add product {partial_hi, multiplier} or the restoring
//   division pair {partial_remainder, dividend/quotient}.
//
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture unsigned magnitudes a_mag/b_mag, clear the counter
//   step       : perform one iteration (one product or quotient bit)
//   div_mode   : 1 = restoring divide step, 0 = shift-add multiply step
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   acc        : {hi, lo} iteration register (product or {remainder, quotient})
//   last_step  : the current step is the final (WIDTH-th) one
// -----------------------------------------------------------------------------
module muldiv_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic               last_step
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    mul_sum   = '0;
    div_shift = '0;
    div_fits  = 1'b0;
    div_rem   = '0;
    acc_next  = acc_q;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole pair right one place. The
    // carry out of the add becomes the new top bit.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor only if it fits. The remainder is always below the
    // divisor, so the subtraction result fits in WIDTH bits.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opb_q});
    div_rem   = div_fits ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];

    if (div_mode) begin
      acc_next = {div_rem, acc_q[WIDTH-2:0], div_fits};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // NOTE: these are ordinary registers, not a memory array, so they are all
  // reset to keep simulation and silicon in the same known state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= {{WIDTH{1'b0}}, a_mag};
      opb_q <= b_mag;
      cnt_q <= '0;
    end else if (step) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc       = acc_q;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative multiply/divide unit owning the architectural HI/LO pair.
//   Executes mult, multu, madd, msub, div, divu (WIDTH iterations each, plus a
//   fix-up cycle) and single-cycle mthi/mtlo.
//
//   Clk      : rising-edge clock
//   Reset    : asynchronous active-high reset, aborts any op in flight
//   Start    : request strobe, sampled only while Busy=0
//   MdOp     : operation code (see md_op_e)
//   A, B     : rs / rt operands
//   Busy     : iterative op in flight (MUL, DIV or FIN state)
//   Done     : one-cycle pulse in the cycle after HI/LO commit
//   DivZero  : divide by zero, valid only with Done
//   Hi, Lo   : architectural HI / LO
// -----------------------------------------------------------------------------
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MdOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [WIDTH-1:0] DZ_LO = WIDTH'(DIVZERO_LO);

  state_e state_q, state_d;
  md_op_e op_q;
  md_op_e req_op;
  logic   sign_a_q, sign_b_q;
  logic   dz_q;

  logic               req_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               dp_load, dp_step;
  logic [2*WIDTH-1:0] dp_acc;
  logic               dp_last;

  logic [2*WIDTH-1:0] prod, sprod, old_hilo, res;
  logic [WIDTH-1:0]   quo, rem;
  logic               neg;

  assign req_op     = md_op_e'(MdOp);
  assign req_signed = is_signed_op(req_op);

  // Signed operands enter the datapath as magnitudes; the most negative value
  // maps onto itself, which is the correct unsigned magnitude.
  assign a_mag = (req_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag = (req_signed && B[WIDTH-1]) ? -B : B;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (req_op)
            MD_MULT, MD_MULTU, MD_MADD, MD_MSUB: begin
              dp_load = 1'b1;
              state_d = S_MUL;
            end
            MD_DIV, MD_DIVU: begin
              dp_load = 1'b1;
              // A zero divisor skips the iterations entirely.
              state_d = (B == '0) ? S_FIN : S_DIV;
            end
            default: ; // mthi/mtlo complete in IDLE
          endcase
        end
      end
      S_MUL, S_DIV: begin
        dp_step = 1'b1;
        if (dp_last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operation context captured at the accepting edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q     <= MD_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (dp_load) begin
      op_q     <= req_op;
      sign_a_q <= req_signed & A[WIDTH-1];
      sign_b_q <= req_signed & B[WIDTH-1];
      dz_q     <= is_div_op(req_op) && (B == '0);
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk       (Clk),
    .rst       (Reset),
    .load      (dp_load),
    .step      (dp_step),
    .div_mode  (is_div_op(op_q)),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .acc       (dp_acc),
    .last_step (dp_last)
  );

  // ---------------------------------------------------------------------------
  // Sign fix-up applied in FIN. HI/LO cannot change while Busy, so the value
  // read here for madd/msub is the one present at the Start edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod     = dp_acc;
    neg      = sign_a_q ^ sign_b_q;
    sprod    = neg ? -prod : prod;
    old_hilo = {Hi, Lo};
    quo      = dp_acc[WIDTH-1:0];
    rem      = dp_acc[2*WIDTH-1:WIDTH];
    res      = old_hilo;

    case (op_q)
      MD_MULT:  res = sprod;
      MD_MULTU: res = prod;
      MD_MADD:  res = old_hilo + sprod;
      MD_MSUB:  res = old_hilo - sprod;
      // Quotient truncates toward zero; remainder follows the dividend sign.
      MD_DIV:   res = {(sign_a_q ? -rem : rem), (neg ? -quo : quo)};
      MD_DIVU:  res = {rem, quo};
      default:  res = old_hilo;
    endcase

    // With no iterations run, the low half still holds |A|; restoring the
    // sign gives back the original A for HI.
    if (dz_q) res = {(sign_a_q ? -quo : quo), DZ_LO};
  end

  // ---------------------------------------------------------------------------
  // Architectural HI/LO and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state_q == S_FIN) begin
      {Hi, Lo} <= res;
    end else if (state_q == S_IDLE && Start) begin
      if (req_op == MD_MTHI) Hi <= A;
      if (req_op == MD_MTLO) Lo <= A;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= (state_q == S_FIN);
      DivZero <= (state_q == S_FIN) && dz_q;
    end
  end

  assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//   Directed bench for hilo_muldiv_unit with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int WIDTH = 32;
  localparam int BOUND = 100;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [2:0]       MdOp;
  logic [WIDTH-1:0] A, B;
  logic             Busy, Done, DivZero;
  logic [WIDTH-1:0] Hi, Lo;

  int vectors     = 0;
  int miscompares = 0;
  int lat;
  int done_seen;

  hilo_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .MdOp    (MdOp),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, let one rising edge sample it, then drop Start.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MdOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Count cycles after the Start edge until Done is seen (sampled on negedge).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < BOUND) begin
      @(negedge Clk);
      cycles++;
      if (Done) return;
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MdOp = '0; A = '0; B = '0;
    #3;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    check("reset_divzero", {63'd0, DivZero}, 64'd0);
    check("reset_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk); Reset = 1'b0;

    // Reset mid-MUL aborts the op and clears HI/LO.
    start_op(MD_MTHI, 32'h0000_1234, 32'h0);
    check("mthi_pre_abort", {32'd0, Hi}, 64'h1234);
    start_op(MD_MULT, 32'd5, 32'd7);
    check("abort_busy_rises", {63'd0, Busy}, 64'd1);
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk); Reset = 1'b0;
    done_seen = 0;
    repeat (50) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // MULT -2 * 3
    start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    check("mult_latency", 64'(lat), 64'd34);
    check("mult_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_busy_at_done", {63'd0, Busy}, 64'd0);
    check("mult_divzero", {63'd0, DivZero}, 64'd0);

    // MULTU 0xFFFFFFFE * 3
    start_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    check("multu_hilo", {Hi, Lo}, 64'h0000_0002_FFFF_FFFA);

    // MTHI / MTLO then MADD / MSUB
    start_op(MD_MTHI, 32'h1, 32'h0);
    check("mthi_hi", {32'd0, Hi}, 64'h1);
    check("mthi_no_busy", {63'd0, Busy}, 64'd0);
    start_op(MD_MTLO, 32'h0, 32'h0);
    check("mtlo_hilo", {Hi, Lo}, 64'h0000_0001_0000_0000);
    check("mtlo_no_done", {63'd0, Done}, 64'd0);
    start_op(MD_MADD, 32'hFFFF_FFFF, 32'd2);
    check("madd_hilo_frozen", {Hi, Lo}, 64'h0000_0001_0000_0000);
    wait_done(lat);
    check("madd_hilo", {Hi, Lo}, 64'h0000_0000_FFFF_FFFE);
    start_op(MD_MSUB, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat);
    check("msub_hilo", {Hi, Lo}, 64'h0000_0001_0000_0000);

    // DIV -7 / 2
    start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("div_latency", 64'(lat), 64'd34);
    check("div_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_divzero", {63'd0, DivZero}, 64'd0);

    // DIV 7 / -2
    start_op(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    check("div_negdivisor_hilo", {Hi, Lo}, 64'h0000_0001_FFFF_FFFD);

    // DIV overflow case wraps silently
    start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("div_ovf_hilo", {Hi, Lo}, 64'h0000_0000_8000_0000);
    check("div_ovf_divzero", {63'd0, DivZero}, 64'd0);

    // DIVU 7 / 0
    start_op(MD_DIVU, 32'd7, 32'd0);
    wait_done(lat);
    check("divu0_latency", 64'(lat), 64'd2);
    check("divu0_hilo", {Hi, Lo}, 64'h0000_0007_FFFF_FFFF);
    check("divu0_divzero", {63'd0, DivZero}, 64'd1);
    @(negedge Clk);
    check("divu0_done_drops", {63'd0, Done}, 64'd0);
    check("divu0_divzero_drops", {63'd0, DivZero}, 64'd0);

    // DIV -5 / 0 returns the original signed A in HI
    start_op(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat);
    check("div0_hilo", {Hi, Lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    check("div0_divzero", {63'd0, DivZero}, 64'd1);

    // DIVU 100 / 7 with Start hammered every busy cycle
    start_op(MD_DIVU, 32'd100, 32'd7);
    lat = 0;
    while (lat < BOUND) begin
      @(negedge Clk);
      lat++;
      if (Done) break;
      Start = 1'b1;
      MdOp  = 3'(lat % 8);
      A     = $urandom;
      B     = $urandom;
    end
    check("spam_latency", 64'(lat), 64'd34);
    check("spam_hilo", {Hi, Lo}, 64'h0000_0002_0000_000E);

    // Back-to-back MULT issued in the Done cycle
    start_op(MD_MULT, 32'd6, 32'd7);
    check("b2b_busy", {63'd0, Busy}, 64'd1);
    check("b2b_hilo_held", {Hi, Lo}, 64'h0000_0002_0000_000E);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_hilo", {Hi, Lo}, 64'h0000_0000_0000_002A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO pair.
- Sits beside the ALU in the execute stage. It consumes the operands A/B and feeds Hi/Lo back to the ALU as Hi_in/Lo_in for mfhi/mflo.
- Executes mult, multu, madd, msub, div, divu, mthi and mtlo.
- Raises Busy so the hazard unit stalls any HI/LO consumer until the result is committed.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration-counter width (must hold WIDTH).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request strobe; sampled only when Busy=0.
- MdOp  in  3  0=MULT 1=MULTU 2=MADD 3=MSUB 4=DIV 5=DIVU 6=MTHI 7=MTLO.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- Busy  out  1  high while an iterative op is in flight.
- Done  out  1  one-cycle pulse after HI/LO commit.
- DivZero  out  1  valid with Done; set for div/divu with B=0.
- Hi  out  WIDTH  architectural HI.
- Lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (async, any state, including mid-operation): the current op is aborted and discarded.
  - State=IDLE; Hi=0, Lo=0; Busy=0, Done=0, DivZero=0; counter=0.
- States: IDLE, MUL, DIV, FIN.
- IDLE, Start=1:
  - MTHI: Hi<=A at that edge; Lo unchanged. MTLO: Lo<=A likewise. Both stay in IDLE with no Busy and no Done.
  - MULT/MULTU/MADD/MSUB: latch operands and MdOp, go to MUL. For signed ops the operands are latched as magnitudes plus sign bits.
  - DIV/DIVU: latch operands the same way, go to DIV.
  - MdOp>7 is impossible (3-bit field); no other codes exist.
- MUL: radix-2 shift-add, one bit per cycle, exactly WIDTH cycles, then FIN.
- DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then FIN.
  - If B=0 at Start: go straight to FIN with DivZero latched (no iterations).
- FIN (1 cycle): apply corrections, commit {Hi,Lo} at the exit edge, return to IDLE.
  - MULT: {Hi,Lo}=signed 64-bit product (negated if the operand signs differ).
  - MULTU: {Hi,Lo}=unsigned product.
  - MADD: {Hi,Lo}=old{Hi,Lo}+signed product, modulo 2^64.
  - MSUB: {Hi,Lo}=old{Hi,Lo}-signed product, modulo 2^64.
  - DIV: Lo=quotient truncated toward zero; Hi=remainder carrying the sign of the dividend.
  - DIV 0x80000000/0xFFFFFFFF: Lo=0x80000000, Hi=0 (wraps, no flag).
  - DIVU: unsigned Lo=quotient, Hi=remainder.
  - Divide by zero (signed or unsigned): Hi=A, Lo=0xFFFFFFFF, DivZero=1.
- Busy is high in MUL, DIV and FIN.
  - Latency: Start at edge n, Busy high in cycles n+1..n+WIDTH+1, Hi/Lo valid and Done=1 in cycle n+WIDTH+2. Divide-by-zero: Hi/Lo valid and Done=1 in cycle n+2.
- Done is high for exactly one cycle, with Busy=0; DivZero is 0 whenever Done=0.
- Start while Busy=1 is ignored: no queueing, operands unchanged, no error.
- Start in the Done cycle is accepted normally (back-to-back ops).
- Hi/Lo never change mid-operation; intermediate values live in internal registers only.
- madd/msub read old {Hi,Lo} at the Start edge, not at FIN.

Decomposition:
- Shared package (or header):
  - MdOp encodings MD_MULT..MD_MTLO.
  - State encodings S_IDLE, S_MUL, S_DIV, S_FIN.
  - Constant DIVZERO_LO=32'hFFFFFFFF.
- One natural sub-module: muldiv_datapath. It holds the shift/add/subtract iteration registers (accumulator, multiplicand, partial remainder, counter) and is stepped by the FSM.
- The top level keeps the FSM, sign fixup and the HI/LO registers.

Test Plan:
- Reset asserted mid-MUL at cycle 10 → Busy=0 and Hi=Lo=0 immediately; after deassert no Done ever fires for the aborted op.
- MULT A=0xFFFFFFFE (-2), B=3 → Done at Start+34; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULTU on the same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
- MTHI A=0x1, MTLO A=0x0, then MADD A=0xFFFFFFFF, B=0x2 → {Hi,Lo}=0x0000_0000_FFFF_FFFE. Then MSUB with the same operands → {Hi,Lo}=0x0000_0001_0000_0000.
- DIV A=-7 (0xFFFFFFF9), B=2 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), DivZero=0. DIVU A=7, B=0 → Done at Start+2, Hi=7, Lo=0xFFFFFFFF, DivZero=1.
- Start asserted every cycle during a DIV with changing A/B → only the first op runs and its result is unaffected. A new MULT issued in the Done cycle is accepted, and Busy rises the next cycle.
